// File: rtl/req_gnt_pkg.sv
// Shared types and defaults for the req/gnt requester agent.
//   state_e    : FSM encoding (IDLE/REQ/OWN/GAP = 0..3)
//   DEF_*      : default parameter values
//   tmo_cnt_w  : width of the counter that tracks cycles spent waiting in REQ
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_TIMEOUT = 32;
  localparam int unsigned DEF_CNT_W   = 8;

  // The wait counter only needs to reach TIMEOUT-1.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/req_gnt_client_if.sv
// Bundle of the job handshake, resolver handshake and status signals of one
// requester agent.
//   master : the agent side (drives job_ready/req/xfer/done/timeout/status)
//   slave  : the job source / resolver / observer side
interface req_gnt_client_if
  import req_gnt_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             gnt;
  logic             req;
  logic             xfer;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] preempt_cnt;
  logic             err_spurious;

  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, xfer, done, timeout, preempt_cnt, err_spurious
  );

  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, xfer, done, timeout, preempt_cnt, err_spurious
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (wins over inc)
//   inc      : increment, holding at all-ones
//   cnt      : registered count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/req_gnt_client.sv
// Requester-side agent for one line of a 4-way req/gnt priority resolver.
// Accepts a burst job, holds req until job_len+1 granted beats have been
// seen, and handles preemption, request timeout and spurious grants.
//   clk, rst : clock, synchronous active-high reset
//   bus      : job handshake (job_valid/job_len/job_ready), resolver
//              handshake (req/gnt), beat strobe xfer, done/timeout pulses,
//              preempt_cnt and sticky err_spurious
module req_gnt_client
  import req_gnt_pkg::*;
#(
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  req_gnt_client_if.master bus
);

  localparam int unsigned REM_W  = LEN_W + 1;
  localparam int unsigned WAIT_W = tmo_cnt_w(TIMEOUT);

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;

  logic              wait_clr, wait_inc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pc_inc;
  logic [CNT_W-1:0]  preempt_cnt;
  logic              job_ready_c;

  // Ready is suppressed during reset so a job offered then is never lost.
  assign job_ready_c = (state_q == IDLE) && !rst;

  // Cycles spent in REQ without a grant since the last (re)request.
  sat_counter #(.W(WAIT_W)) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

  // Preemptions since reset.
  sat_counter #(.W(CNT_W)) u_preempt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (pc_inc),
    .cnt (preempt_cnt)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    req_d     = req_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = err_q;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    pc_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.gnt) begin
          err_d = 1'b1;
        end
        if (bus.job_valid && job_ready_c) begin
          rem_d    = REM_W'(bus.job_len) + REM_W'(1);
          wait_clr = 1'b1;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end

      REQ: begin
        // A grant arriving on the expiry cycle still wins.
        if (bus.gnt) begin
          state_d = OWN;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          rem_d     = '0;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          wait_inc = 1'b1;
        end
      end

      OWN: begin
        if (bus.gnt) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          // Grant withdrawn mid-burst: keep remaining beats and re-request.
          wait_clr = 1'b1;
          pc_inc   = 1'b1;
          state_d  = REQ;
        end
      end

      GAP: begin
        // One dead cycle soaks up the resolver's registered grant.
        state_d = IDLE;
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      req_q     <= req_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.job_ready    = job_ready_c;
  assign bus.req          = req_q;
  assign bus.xfer         = (state_q == OWN) && bus.gnt;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.preempt_cnt  = preempt_cnt;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_req_gnt_client.sv
// Bench for req_gnt_client: four agents sharing a fixed-priority resolver
// with a registered grant, plus directed grant driving per agent.
module tb_req_gnt_client;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int          K_DONE  = 0;
  localparam int          K_TMO   = 1;
  localparam int          K_ANY   = 2;

  typedef struct {
    int beats;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       job_valid = '0;
  logic [LEN_W-1:0] job_len [4];
  logic [3:0]       gnt_drv = '0;
  logic [3:0]       gnt_res;
  logic             res_en = 1'b0;

  logic [3:0]       job_ready_w, req_w, xfer_w, done_w, timeout_w, err_w;
  logic [CNT_W-1:0] pc_w [4];

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q [4][$];
  int   beats [4];
  int   tot_xfer [4];
  int   sum_done_exp [4];
  int   abort_beats [4];
  int   done_cnt [4];
  int   multi_x = 0;

  req_gnt_client_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_cli
    assign bus_if[g].job_valid = job_valid[g];
    assign bus_if[g].job_len   = job_len[g];
    assign bus_if[g].gnt       = res_en ? gnt_res[g] : gnt_drv[g];
    assign job_ready_w[g]      = bus_if[g].job_ready;
    assign req_w[g]            = bus_if[g].req;
    assign xfer_w[g]           = bus_if[g].xfer;
    assign done_w[g]           = bus_if[g].done;
    assign timeout_w[g]        = bus_if[g].timeout;
    assign err_w[g]            = bus_if[g].err_spurious;
    assign pc_w[g]             = bus_if[g].preempt_cnt;

    req_gnt_client #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if[g])
    );
  end

  // Resolver model: lowest index wins, grant registered one cycle after req.
  always @(posedge clk) begin
    if (rst) gnt_res <= '0;
    else     gnt_res <= req_w & (~req_w + 4'd1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: beats per job, checked against the pushed expectation.
  always @(negedge clk) begin
    if ($countones(xfer_w) > 1) multi_x++;
    for (int i = 0; i < 4; i++) begin
      if (xfer_w[i]) begin
        beats[i]++;
        tot_xfer[i]++;
      end
      if (rst) begin
        abort_beats[i] += beats[i];
        beats[i] = 0;
        exp_q[i].delete();
      end else if (done_w[i] || timeout_w[i]) begin
        chk($sformatf("sb_pending%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
        if (exp_q[i].size() != 0) begin
          exp_t e;
          e = exp_q[i].pop_front();
          if (done_w[i]) begin
            done_cnt[i]++;
            chk($sformatf("sb_beats%0d", i), 64'(beats[i]), 64'(e.beats));
            chk($sformatf("sb_not_tmo%0d", i), 64'(e.kind != K_TMO), 64'd1);
            sum_done_exp[i] += e.beats;
          end else begin
            chk($sformatf("sb_not_done%0d", i), 64'(e.kind != K_DONE), 64'd1);
            abort_beats[i] += beats[i];
          end
        end
        beats[i] = 0;
      end
    end
  end

  // Offer one job on client 0, then drive gnt from pat[k] for cycles 1..ncyc
  // after the accepting edge, recording outputs per cycle.
  task automatic run_job(input int len, input int kind, input logic [63:0] pat,
                         input int ncyc, output logic [63:0] rq, output logic [63:0] xf,
                         output logic [63:0] dn, output logic [63:0] to,
                         output logic [63:0] jr);
    exp_t e;
    rq = '0; xf = '0; dn = '0; to = '0; jr = '0;
    chk("accept_ready", 64'(job_ready_w[0]), 64'd1);
    e.beats = len + 1;
    e.kind  = kind;
    exp_q[0].push_back(e);
    job_valid[0] = 1'b1;
    job_len[0]   = LEN_W'(len);
    gnt_drv[0]   = 1'b0;
    tick();
    job_valid[0] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      gnt_drv[0] = pat[k];
      #1;
      rq[k] = req_w[0];
      xf[k] = xfer_w[0];
      dn[k] = done_w[0];
      to[k] = timeout_w[0];
      jr[k] = job_ready_w[0];
      tick();
    end
    gnt_drv[0] = 1'b0;
  endtask

  initial begin
    logic [63:0] rq, xf, dn, to, jr;
    exp_t e;
    int dn_before;
    for (int i = 0; i < 4; i++) begin
      job_len[i] = '0;
      beats[i] = 0; tot_xfer[i] = 0; sum_done_exp[i] = 0;
      abort_beats[i] = 0; done_cnt[i] = 0;
    end

    // Reset values.
    tick(); tick();
    chk("rst_job_ready", 64'(job_ready_w), 64'h0);
    chk("rst_req", 64'(req_w), 64'h0);
    chk("rst_done", 64'(done_w | timeout_w), 64'h0);
    chk("rst_err", 64'(err_w), 64'h0);
    chk("rst_pc", 64'(pc_w[0]), 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(job_ready_w), 64'hF);
    tick();

    // Basic 4-beat burst; grant lingers into GAP but not into IDLE.
    run_job(3, K_DONE, 64'h7E, 7, rq, xf, dn, to, jr);
    chk("basic_req", rq, 64'h3E);
    chk("basic_xfer", xf, 64'h3C);
    chk("basic_done", dn, 64'h40);
    chk("basic_tmo", to, 64'h0);
    chk("basic_ready", jr, 64'h80);
    chk("late_gnt_err", 64'(err_w[0]), 64'h0);

    // Preemption after one beat, three cycles without grant.
    run_job(2, K_DONE, 64'h3C6, 11, rq, xf, dn, to, jr);
    chk("pre_req", rq, 64'h1FE);
    chk("pre_xfer", xf, 64'h184);
    chk("pre_done", dn, 64'h200);
    chk("pre_ready", jr, 64'hC00);
    chk("pre_cnt", 64'(pc_w[0]), 64'd1);
    chk("pre_err", 64'(err_w[0]), 64'h0);

    // Timeout: 32 cycles of req with no grant.
    run_job(5, K_TMO, 64'h0, 35, rq, xf, dn, to, jr);
    chk("tmo_req", rq, 64'h1_FFFF_FFFE);
    chk("tmo_pulse", to, 64'h2_0000_0000);
    chk("tmo_done", dn, 64'h0);
    chk("tmo_xfer", xf, 64'h0);
    chk("tmo_ready", jr, 64'hC_0000_0000);

    // Spurious grant in IDLE is sticky.
    gnt_drv[0] = 1'b1;
    tick();
    gnt_drv[0] = 1'b0;
    chk("spur_set", 64'(err_w[0]), 64'h1);
    repeat (4) tick();
    chk("spur_hold", 64'(err_w[0]), 64'h1);

    // Reset mid-burst with five beats outstanding.
    e.beats = 10; e.kind = K_DONE;
    exp_q[0].push_back(e);
    job_valid[0] = 1'b1; job_len[0] = LEN_W'(9); gnt_drv[0] = 1'b1;
    tick();
    job_valid[0] = 1'b0;
    repeat (6) tick();
    chk("mid_req", 64'(req_w[0]), 64'h1);
    chk("mid_xfer", 64'(xfer_w[0]), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(job_ready_w[0]), 64'h0);
    tick();
    chk("mid_rst_req", 64'(req_w[0]), 64'h0);
    chk("mid_rst_xfer", 64'(xfer_w[0]), 64'h0);
    chk("mid_rst_pulses", 64'(done_w[0] | timeout_w[0]), 64'h0);
    chk("mid_rst_pc", 64'(pc_w[0]), 64'h0);
    chk("mid_rst_err", 64'(err_w[0]), 64'h0);
    gnt_drv[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_ready", 64'(job_ready_w[0]), 64'h1);
    dn_before = done_cnt[0];
    repeat (12) tick();
    chk("mid_no_done", 64'(done_cnt[0]), 64'(dn_before));
    chk("mid_idle_req", 64'(req_w[0]), 64'h0);

    // Thrash client 2: grant toggles every cycle, no beat ever lands.
    e.beats = 16; e.kind = K_DONE;
    exp_q[2].push_back(e);
    job_valid[2] = 1'b1; job_len[2] = LEN_W'(15);
    tick();
    job_valid[2] = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      gnt_drv[2] = (k % 2) == 1;
      tick();
    end
    chk("thrash_100", 64'(pc_w[2]), 64'd100);
    chk("thrash_req", 64'(req_w[2]), 64'h1);
    for (int k = 201; k <= 600; k++) begin
      gnt_drv[2] = (k % 2) == 1;
      tick();
    end
    chk("thrash_sat", 64'(pc_w[2]), 64'd255);
    gnt_drv[2] = 1'b1;
    repeat (17) tick();
    chk("thrash_done", 64'(done_w[2]), 64'h1);
    gnt_drv[2] = 1'b0;
    tick();
    chk("thrash_sat_hold", 64'(pc_w[2]), 64'd255);

    // Four clients on the resolver with random jobs.
    res_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        job_valid[i] = ($urandom_range(0, 39) == 0);
        job_len[i]   = LEN_W'($urandom_range(0, 15));
        if (job_valid[i] && job_ready_w[i]) begin
          e.beats = int'(job_len[i]) + 1;
          e.kind  = K_ANY;
          exp_q[i].push_back(e);
        end
      end
      tick();
    end
    job_valid = '0;
    for (int c = 0; c < 400 && job_ready_w != 4'hF; c++) tick();
    chk("drain_idle", 64'(job_ready_w), 64'hF);
    tick();

    chk("one_xfer_per_cycle", 64'(multi_x), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("xfer_total%0d", i), 64'(tot_xfer[i]),
          64'(sum_done_exp[i] + abort_beats[i]));
      chk($sformatf("sb_empty%0d", i), 64'(exp_q[i].size()), 64'd0);
      chk($sformatf("final_err%0d", i), 64'(err_w[i]), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/req_gnt_client.md
Name: req_gnt_client

Overview:
- Requester-side agent for the 4-way req/gnt priority resolver; one instance drives each req_x line and consumes the matching gnt_x.
- Accepts a job (burst length) over a valid/ready handshake and raises req.
- Holds req until the burst has received the programmed number of granted beats, then releases.
- Handles preemption (gnt withdrawn mid-burst), request timeout, and spurious grants.

Parameters:
- LEN_W, 4, width of job_len; burst = job_len+1 granted beats (1..16).
- TIMEOUT, 32, max consecutive cycles in REQ without gnt before abort (>=2).
- CNT_W, 8, width of saturating preempt counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- job_valid  input  1  job offered
- job_len  input  LEN_W  beats minus one
- job_ready  output  1  client can accept a job
- gnt  input  1  grant from priority resolver
- req  output  1  request to priority resolver
- xfer  output  1  granted beat this cycle
- done  output  1  one-cycle pulse: burst completed
- timeout  output  1  one-cycle pulse: request aborted
- preempt_cnt  output  CNT_W  saturating count of preemptions since reset
- err_spurious  output  1  sticky: gnt seen while idle

Behaviour:
- States: IDLE, REQ, OWN, GAP. All outputs registered except xfer.
- Reset (synchronous; any state, including mid-burst): state=IDLE, req=0, done=0, timeout=0, preempt_cnt=0, err_spurious=0, remaining=0, wait counter=0. req drops at the edge where rst is sampled high.
- job_ready = (state==IDLE) && !rst.
- xfer = (state==OWN) && gnt (combinational).
- IDLE:
  - job_valid&&job_ready at edge t: remaining <= job_len+1, wait <= 0, state -> REQ; req=1 from cycle t+1.
  - gnt==1 sampled in IDLE: err_spurious <= 1, held until reset. No other effect.
- REQ (req=1):
  - gnt==1: -> OWN. That cycle is not a beat.
  - Else wait++. If wait==TIMEOUT-1: -> GAP, req <= 0, timeout pulses during the GAP cycle, job discarded, done not asserted.
- OWN (req=1):
  - gnt==1: beat; remaining--.
  - Beat with remaining==1: -> GAP, req <= 0, done pulses during the GAP cycle.
  - gnt==0: preemption; -> REQ, wait <= 0, remaining kept, preempt_cnt++ (saturates at all-ones).
- GAP (req=0): exactly one cycle. Absorbs the resolver's registered late gnt; gnt here is ignored and not flagged. -> IDLE.
- Back-to-back jobs: minimum spacing from done to the next req rise is 2 cycles (GAP, then IDLE accepting).
- Simultaneous events:
  - Timeout expiry and gnt in the same cycle: gnt wins (-> OWN).
  - rst has priority over all events.
- job_len=0: single beat; OWN lasts exactly one granted cycle.

Decomposition:
- Package req_gnt_pkg:
  - state enum (IDLE/REQ/OWN/GAP, 2-bit encoding 0..3)
  - default LEN_W/TIMEOUT/CNT_W constants
  - function returning the counter width for TIMEOUT (clog2)
- One sub-module sat_counter (parameterized width, inc, clear, saturating), instanced for the wait counter and preempt_cnt.
- FSM and beat counter stay in the top.

Test Plan:
- Basic burst: job_len=3 accepted at t, gnt tied 1 -> req high t+1..t+5, xfer high t+2..t+5 (4 beats), done pulse at t+6 with req=0, job_ready=1 at t+7.
- Preemption: job_len=2; gnt high for 1 beat, low 3 cycles, high again -> preempt_cnt=1, req stays high throughout, exactly 3 xfer cycles total, single done pulse.
- Timeout: TIMEOUT=32, gnt held 0 after job accepted -> req high exactly 32 cycles, timeout pulse 1 cycle, no done, no xfer, back to IDLE.
- Late/spurious grant:
  - gnt held 1 one cycle past the final beat (GAP) -> err_spurious stays 0.
  - gnt=1 for one cycle in IDLE -> err_spurious=1 and remains 1 until rst.
- Reset mid-burst: rst asserted for 1 cycle in OWN with remaining=5 -> req=0 and all outputs zero the next cycle, job_ready=1 after rst deasserts, no done.
- Four clients on the 4-way resolver, random job_len, random job_valid over 2000 cycles:
  - never more than one xfer high per cycle
  - total xfer count per client = sum of (job_len+1) over its completed jobs
  - preempt_cnt saturates at 255 under forced thrashing
